// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port cache-line memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin pick between the I- and D-cache requesters.
module mem_arb_rr
    import mem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   ireq_i,
    input  logic   dreq_i,
    input  logic   take_i,
    output logic   gnt_vld_o,
    output owner_e gnt_own_o
);

    owner_e last_q;

    // On a tie the requester that did not own the previous grant wins.
    always_comb begin
        gnt_vld_o = ireq_i | dreq_i;
        if (ireq_i && dreq_i) begin
            gnt_own_o = (last_q == OWN_I) ? OWN_D : OWN_I;
        end else if (dreq_i) begin
            gnt_own_o = OWN_D;
        end else begin
            gnt_own_o = OWN_I;
        end
    end

    // Last-owner flag, updated only when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWN_I;
        end else if (take_i) begin
            last_q <= gnt_own_o;
        end else begin
            last_q <= last_q;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I- and D-cache line requests onto a single memory port,
// one transaction at a time, with registered strobes and completion pulses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q;
    owner_e            owner_q;
    logic              op_wr_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              i_ready_q;
    logic              d_ready_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              gnt_vld_s;
    owner_e            gnt_own_s;
    logic              take_s;
    logic              sel_wr_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    mem_arb_rr u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .ireq_i    (i_read | i_write),
        .dreq_i    (d_read | d_write),
        .take_i    (take_s),
        .gnt_vld_o (gnt_vld_s),
        .gnt_own_o (gnt_own_s)
    );

    // Mux the winner's request; write beats read from the same requester.
    always_comb begin
        take_s = (state_q == ST_IDLE) && gnt_vld_s;
        if (gnt_own_s == OWN_D) begin
            sel_wr_s    = d_write;
            sel_addr_s  = d_addr;
            sel_wdata_s = d_wdata;
        end else begin
            sel_wr_s    = i_write;
            sel_addr_s  = i_addr;
            sel_wdata_s = i_wdata;
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_I;
            op_wr_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    i_ready_q <= 1'b0;
                    d_ready_q <= 1'b0;
                    if (take_s) begin
                        owner_q     <= gnt_own_s;
                        op_wr_q     <= sel_wr_s;
                        mem_addr_q  <= sel_addr_s;
                        mem_wdata_q <= sel_wdata_s;
                        mem_read_q  <= ~sel_wr_s;
                        mem_write_q <= sel_wr_s;
                        state_q     <= ST_SERVE;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                ST_SERVE: begin
                    if (mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (!op_wr_q && (owner_q == OWN_D)) begin
                            d_rdata_q <= mem_rdata;
                        end else if (!op_wr_q) begin
                            i_rdata_q <= mem_rdata;
                        end else begin
                            d_rdata_q <= d_rdata_q;
                        end
                        i_ready_q <= (owner_q == OWN_I);
                        d_ready_q <= (owner_q == OWN_D);
                        state_q   <= ST_RELEASE;
                    end else begin
                        state_q   <= ST_SERVE;
                    end
                end
                ST_RELEASE: begin
                    i_ready_q <= 1'b0;
                    d_ready_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    i_ready_q   <= 1'b0;
                    d_ready_q   <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, hand sequences and
// randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam logic [AW-1:0] IA  = 28'h0000010;
    localparam logic [AW-1:0] DA  = 28'h0000020;
    localparam logic [DW-1:0] A5  = {16{8'hA5}};
    localparam logic [DW-1:0] R5A = {16{8'h5A}};
    localparam logic [DW-1:0] C1  = {4{32'hC0DE_0001}};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read, i_write, d_read, d_write, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata, mem_rdata;
    logic          i_ready, d_ready, mem_read, mem_write;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_ready(i_ready), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: one transaction record plus per-port read data.
    bit            m_busy, m_ack, m_own, m_wr, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rd [2];

    typedef struct {
        logic ir, iw, dr, dw, mr;
        logic e_rd, e_wr, e_irdy, e_drdy, e_addr_d;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_ack = 1'b0; m_own = 1'b0; m_wr = 1'b0; m_last = 1'b0;
        m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit ri, rd;
        ri = i_read | i_write;
        rd = d_read | d_write;
        if (m_ack) begin
            m_ack = 1'b0;
        end else if (m_busy) begin
            if (mem_ready) begin
                m_busy = 1'b0;
                m_ack  = 1'b1;
                if (!m_wr) m_rd[m_own] = mem_rdata;
            end
        end else if (ri || rd) begin
            m_own   = (ri && rd) ? !m_last : rd;
            m_last  = m_own;
            m_busy  = 1'b1;
            m_wr    = m_own ? d_write : i_write;
            m_addr  = m_own ? d_addr : i_addr;
            m_wdata = m_own ? d_wdata : i_wdata;
        end
    endtask

    task automatic model_check();
        chk("mem_read",  mem_read,  m_busy && !m_wr);
        chk("mem_write", mem_write, m_busy && m_wr);
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("i_ready",   i_ready,   m_ack && !m_own);
        chk("d_ready",   d_ready,   m_ack && m_own);
        chk("i_rdata",   i_rdata,   m_rd[0]);
        chk("d_rdata",   d_rdata,   m_rd[1]);
        chk("strobe_excl", mem_read & mem_write, 1'b0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_rd"},   mem_read,  1'b0);
        chk({nm, "_wr"},   mem_write, 1'b0);
        chk({nm, "_addr"}, mem_addr,  '0);
        chk({nm, "_wd"},   mem_wdata, '0);
        chk({nm, "_irdy"}, i_ready,   1'b0);
        chk({nm, "_drdy"}, d_ready,   1'b0);
        chk({nm, "_ird"},  i_rdata,   '0);
        chk({nm, "_drd"},  d_rdata,   '0);
    endtask

    initial begin
        // Both requesters held, memory always ready: D,I,D,I with idle gaps.
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b1};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b1};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b1};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b1};
        tbl[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1};
        tbl[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0};

        rst_n = 1'b0;
        i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = IA; d_addr = DA; i_wdata = '0; d_wdata = 128'h1234;
        mem_ready = 1'b0; mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Simultaneous requests from reset and round-robin fairness.
        mem_rdata = C1;
        for (int k = 0; k < 12; k++) begin
            i_read = tbl[k].ir; i_write = tbl[k].iw;
            d_read = tbl[k].dr; d_write = tbl[k].dw;
            mem_ready = tbl[k].mr;
            tick();
            chk("tbl_rd",   mem_read,  tbl[k].e_rd);
            chk("tbl_wr",   mem_write, tbl[k].e_wr);
            chk("tbl_irdy", i_ready,   tbl[k].e_irdy);
            chk("tbl_drdy", d_ready,   tbl[k].e_drdy);
            chk("tbl_addr", mem_addr,  tbl[k].e_addr_d ? DA : IA);
        end
        i_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
        tick();

        // Single read with memory answering on the fourth strobe cycle.
        i_addr = IA; i_read = 1'b1;
        tick();
        chk("sr_strobe", mem_read, 1'b1);
        i_read = 1'b0;
        repeat (3) tick();
        chk("sr_hold", mem_read, 1'b1);
        mem_ready = 1'b1; mem_rdata = A5;
        tick();
        chk("sr_ready", i_ready, 1'b1);
        chk("sr_rdata", i_rdata, A5);
        chk("sr_drop", mem_read, 1'b0);
        mem_ready = 1'b0;
        tick();
        chk("sr_pulse", i_ready, 1'b0);

        // Seed d_rdata with a read, then a D write must leave it alone.
        d_read = 1'b1;
        tick();
        d_read = 1'b0; mem_ready = 1'b1; mem_rdata = R5A;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("dr_seed", d_rdata, R5A);
        d_write = 1'b1; d_wdata = 128'h1234;
        tick();
        chk("dw_strobe", mem_write, 1'b1);
        chk("dw_wdata", mem_wdata, 128'h1234);
        d_write = 1'b0; mem_ready = 1'b1; mem_rdata = {4{32'hDEAD_BEEF}};
        tick();
        chk("dw_ready", d_ready, 1'b1);
        chk("dw_rdata_kept", d_rdata, R5A);
        mem_ready = 1'b0;
        tick();

        // mem_ready in IDLE is ignored; input changes during SERVE are ignored.
        mem_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("ign_idle", {mem_read, mem_write, i_ready, d_ready}, 4'b0000);
        end
        mem_ready = 1'b0; i_addr = IA; i_read = 1'b1;
        tick();
        i_read = 1'b0; i_addr = 28'h0ABCDEF; i_write = 1'b1;
        tick();
        chk("ign_addr", mem_addr, IA);
        chk("ign_op", mem_read, 1'b1);
        i_write = 1'b0; mem_ready = 1'b1; mem_rdata = C1;
        tick();
        mem_ready = 1'b0;
        tick();

        // Asynchronous reset in the middle of SERVE.
        i_addr = IA; i_read = 1'b1;
        tick();
        i_read = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        model_reset();
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        rst_n = 1'b1; mem_ready = 1'b0;
        i_addr = 28'h0000040; i_read = 1'b1;
        tick();
        chk("post_rst_strobe", mem_read, 1'b1);
        chk("post_rst_addr", mem_addr, 28'h0000040);
        i_read = 1'b0; mem_ready = 1'b1; mem_rdata = A5;
        tick();
        chk("post_rst_ready", i_ready, 1'b1);
        chk("post_rst_rdata", i_rdata, A5);
        mem_ready = 1'b0;
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            i_read    = ($urandom_range(0, 2) == 0);
            i_write   = ($urandom_range(0, 3) == 0);
            d_read    = ($urandom_range(0, 2) == 0);
            d_write   = ($urandom_range(0, 3) == 0);
            i_addr    = AW'($urandom);
            d_addr    = AW'($urandom);
            i_wdata   = {$urandom, $urandom, $urandom, $urandom};
            d_wdata   = {$urandom, $urandom, $urandom, $urandom};
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
